// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings and the responder FSM state type.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational RV32I lane logic: load extract/extend, store byte-lane merge and
// legality check. DMEM_MISALIGN_CHK_EN turns misaligned half/word accesses into errors.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         we,
    input  logic [2:0]   funct3,
    input  logic [1:0]   addr_lo,
    input  logic [n-1:0] wdata,
    input  logic [n-1:0] mem_word,
    output logic [n-1:0] rdata,
    output logic [n-1:0] wr_word,
    output logic         err
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic               legal;
    logic               misalign;

    always_comb begin
        byte_s = mem_word[{addr_lo, 3'b000} +: 8];
        half_s = mem_word[{addr_lo[1], 4'b0000} +: 16];

        if (we) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end

`ifdef DMEM_MISALIGN_CHK_EN
        misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]) ||
                   ((funct3 == F3_W) && (addr_lo != 2'b00));
`else
        misalign = 1'b0;
`endif

        err = ~legal | misalign;

        rdata = '0;
        if (!we && !err) begin
            case (funct3)
                F3_B:    rdata = {{(n-8){byte_s[7]}}, byte_s};
                F3_BU:   rdata = {{(n-8){1'b0}}, byte_s};
                F3_H:    rdata = {{(n-16){half_s[15]}}, half_s};
                F3_HU:   rdata = {{(n-16){1'b0}}, half_s};
                default: rdata = mem_word;
            endcase
        end

        // Unwritten lanes keep the current word contents.
        wr_word = mem_word;
        case (funct3)
            F3_B:    wr_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    wr_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: wr_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store at a time, fixed LAT-cycle access to a
// word array, response held until taken. Optional DMEM_MISALIGN_CHK_EN (see dmem_align).
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int n    = 32,
    parameter int alen = 6,
    parameter int LAT  = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_rdata,
    output logic         rsp_err
);

    localparam int AW = alen + 2;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [n-1:0]    rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            we_q;
    logic [2:0]      funct3_q;
    logic [AW-1:0]   addr_q;
    logic [n-1:0]    wdata_q;

    logic            cap_en;
    logic            mem_we;
    logic [n-1:0]    mem [2**alen];
    logic [n-1:0]    mem_word;
    logic [n-1:0]    al_rdata;
    logic [n-1:0]    al_wr_word;
    logic            al_err;

    // Address bits above the word index alias onto the array.
    logic            unused_addr_hi;
    assign unused_addr_hi = ^req_addr[n-1:AW];

    assign mem_word = mem[addr_q[AW-1:2]];

    dmem_align #(.n(n)) u_align (
        .we       (we_q),
        .funct3   (funct3_q),
        .addr_lo  (addr_q[1:0]),
        .wdata    (wdata_q),
        .mem_word (mem_word),
        .rdata    (al_rdata),
        .wr_word  (al_wr_word),
        .err      (al_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cap_en  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cap_en  = 1'b1;
                    cnt_d   = 4'(LAT - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rdata_d = al_rdata;
                    err_d   = al_err;
                    mem_we  = we_q & ~al_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (cap_en) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[AW-1:0];
            wdata_q  <= req_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q[AW-1:2]] <= al_wr_word;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: vector table of load/store transactions plus
// hand-written sequences for response back-pressure and reset during BUSY.
module tb_dmem_resp;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    dmem_resp #(.n(32), .alen(6), .LAT(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err);
        vec_t v;
        v.name = nm; v.we = we; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    // One full transaction; hold>0 keeps rsp_ready low for that many cycles of RESP.
    task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic er);
        int lat;
        rd = '0;
        er = 1'b0;
        rsp_ready = (hold == 0);
        @(negedge clock);
        check({nm, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        check({nm, ".latency"}, 32'(lat), 32'(LAT));
        if (!rsp_valid) begin
            rsp_ready = 1'b1;
            return;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clock); #1;
                check({nm, ".held_valid"}, 32'(rsp_valid), 32'd1);
                check({nm, ".held_rdata"}, rsp_rdata, rd);
                check({nm, ".held_req_ready"}, 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clock); #1;
            check({nm, ".released_valid"}, 32'(rsp_valid), 32'd0);
            check({nm, ".released_req_ready"}, 32'(req_ready), 32'd1);
        end else begin
            @(posedge clock); #1;
        end
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        add("sw_8",      1'b1, 3'b010, 32'h8,   32'hDEADBEEF, 32'h0,        1'b0);
        add("lw_8",      1'b0, 3'b010, 32'h8,   32'h0,        32'hDEADBEEF, 1'b0);
        add("lb_8",      1'b0, 3'b000, 32'h8,   32'h0,        32'hFFFFFFEF, 1'b0);
        add("lbu_b",     1'b0, 3'b100, 32'hB,   32'h0,        32'h000000DE, 1'b0);
        add("lh_a",      1'b0, 3'b001, 32'hA,   32'h0,        32'hFFFFDEAD, 1'b0);
        add("lhu_8",     1'b0, 3'b101, 32'h8,   32'h0,        32'h0000BEEF, 1'b0);
        add("sb_9",      1'b1, 3'b000, 32'h9,   32'h00000012, 32'h0,        1'b0);
        add("lw_after_sb", 1'b0, 3'b010, 32'h8, 32'h0,        32'hDEAD12EF, 1'b0);
        add("sh_a",      1'b1, 3'b001, 32'hA,   32'h00005555, 32'h0,        1'b0);
        add("lw_after_sh", 1'b0, 3'b010, 32'h8, 32'h0,        32'h555512EF, 1'b0);
        add("lb_b_pos",  1'b0, 3'b000, 32'hB,   32'h0,        32'h00000055, 1'b0);
        add("lh_8_pos",  1'b0, 3'b001, 32'h8,   32'h0,        32'h000012EF, 1'b0);
        add("ld_f3_011", 1'b0, 3'b011, 32'h8,   32'h0,        32'h0,        1'b1);
        add("lw_after_bad_ld", 1'b0, 3'b010, 32'h8, 32'h0,    32'h555512EF, 1'b0);
        add("st_f3_011", 1'b1, 3'b011, 32'h8,   32'hFFFFFFFF, 32'h0,        1'b1);
        add("ld_f3_110", 1'b0, 3'b110, 32'h8,   32'h0,        32'h0,        1'b1);
        add("st_f3_100", 1'b1, 3'b100, 32'h8,   32'hFFFFFFFF, 32'h0,        1'b1);
        add("lw_after_bad_st", 1'b0, 3'b010, 32'h8, 32'h0,    32'h555512EF, 1'b0);
`ifdef DMEM_MISALIGN_CHK_EN
        add("lw_9_misalign", 1'b0, 3'b010, 32'h9, 32'h0,      32'h0,        1'b1);
`else
        add("lw_9_aligned_down", 1'b0, 3'b010, 32'h9, 32'h0,  32'h555512EF, 1'b0);
`endif
        add("sw_100",    1'b1, 3'b010, 32'h100, 32'h13579BDF, 32'h0,        1'b0);
        add("lw_0_alias", 1'b0, 3'b010, 32'h0,  32'h0,        32'h13579BDF, 1'b0);
        add("sw_4",      1'b1, 3'b010, 32'h4,   32'hCAFEF00D, 32'h0,        1'b0);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.rsp_rdata", rsp_rdata, 32'h0);
        check("reset.rsp_err",   32'(rsp_err), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_req(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0, rd, er);
            check({vecs[i].name, ".rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, ".err"}, 32'(er), 32'(vecs[i].exp_err));
        end

        // Back-pressure: response held for 5 cycles
        do_req("hold_lw_0", 1'b0, 3'b010, 32'h0, 32'h0, 5, rd, er);
        check("hold_lw_0.rdata", rd, 32'h13579BDF);
        check("hold_lw_0.err", 32'(er), 32'd0);

        // Reset during BUSY of a store abandons it
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h4; req_wdata = 32'h00000001;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("rst_busy.in_busy_req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_busy.req_ready", 32'(req_ready), 32'd1);
        check("rst_busy.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy.rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        do_req("lw_4_after_rst", 1'b0, 3'b010, 32'h4, 32'h0, 0, rd, er);
        check("lw_4_after_rst.rdata", rd, 32'hCAFEF00D);
        check("lw_4_after_rst.err", 32'(er), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
